// File: rtl/control_unit.sv
// Instruction sequencer: pops host FIFO words and drives DAC/ADC register accesses over a
// shared SPI master, pushing ADC read results and error words into the readback FIFO.
module control_unit #(
  parameter int         SPI_TIMEOUT = 4096,
  parameter logic [7:0] OP_NOP      = 8'h00,
  parameter logic [7:0] OP_DAC_WR   = 8'h0C,
  parameter logic [7:0] OP_ADC_WR   = 8'h14,
  parameter logic [7:0] OP_ADC_RD   = 8'h18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_ready,
  output logic        instr_ack,
  input  logic [31:0] instr_in,
  input  logic        readback_ready,
  output logic        readback_write,
  output logic [31:0] readback_data,
  output logic        dac_request_write,
  output logic [7:0]  dac_address,
  output logic [15:0] dac_data,
  output logic        adc_request_write,
  output logic        adc_request_read,
  output logic [7:0]  adc_address,
  output logic [15:0] adc_data,
  input  logic [15:0] adc_data_readback,
  input  logic        spi_busy
);

  // state       | meaning
  // IDLE        | waiting for an instruction word
  // DECODE      | instruction captured, ack high, dispatch on opcode
  // REQ         | waiting for SPI idle before raising the request
  // ACCEPT_WAIT | request held until the SPI master goes busy
  // DONE_WAIT   | waiting for the SPI transfer to finish
  // READBACK    | waiting for readback FIFO space, then push
  typedef enum logic [2:0] {
    IDLE, DECODE, REQ, ACCEPT_WAIT, DONE_WAIT, READBACK
  } state_t;

  localparam int TW = $clog2(SPI_TIMEOUT);

  state_t        state;
  logic [31:0]   instr;
  logic [31:0]   rb_word;
  logic [TW-1:0] tmr;
  logic [7:0]    opcode;
  logic [7:0]    addr;
  logic [15:0]   data;
  logic          in_wait;

  assign opcode  = instr[31:24];
  assign addr    = instr[23:16];
  assign data    = instr[15:0];
  assign in_wait = (state == REQ) || (state == ACCEPT_WAIT) || (state == DONE_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      instr             <= '0;
      rb_word           <= '0;
      tmr               <= '0;
      instr_ack         <= 1'b0;
      readback_write    <= 1'b0;
      readback_data     <= '0;
      dac_request_write <= 1'b0;
      dac_address       <= '0;
      dac_data          <= '0;
      adc_request_write <= 1'b0;
      adc_request_read  <= 1'b0;
      adc_address       <= '0;
      adc_data          <= '0;
    end else begin
      instr_ack      <= 1'b0;
      readback_write <= 1'b0;
      if (in_wait) tmr <= tmr - TW'(1);
      // Timer reaching zero in any SPI wait state wins over the normal transition.
      if (in_wait && tmr == '0) begin
        dac_request_write <= 1'b0;
        adc_request_write <= 1'b0;
        adc_request_read  <= 1'b0;
        rb_word           <= {8'hEE, opcode, addr, 8'h00};
        state             <= READBACK;
      end else begin
        case (state)
          IDLE: begin
            if (instr_ready) begin
              instr     <= instr_in;
              instr_ack <= 1'b1;
              state     <= DECODE;
            end
          end
          DECODE: begin
            tmr <= TW'(SPI_TIMEOUT - 1);
            case (opcode)
              OP_NOP: state <= IDLE;
              OP_DAC_WR: begin
                dac_address <= addr;
                dac_data    <= data;
                state       <= REQ;
              end
              OP_ADC_WR, OP_ADC_RD: begin
                adc_address <= addr;
                adc_data    <= data;
                state       <= REQ;
              end
              default: begin
                rb_word <= {8'hFF, opcode, 16'h0000};
                state   <= READBACK;
              end
            endcase
          end
          REQ: begin
            if (!spi_busy) begin
              dac_request_write <= (opcode == OP_DAC_WR);
              adc_request_write <= (opcode == OP_ADC_WR);
              adc_request_read  <= (opcode == OP_ADC_RD);
              state             <= ACCEPT_WAIT;
            end
          end
          ACCEPT_WAIT: begin
            if (spi_busy) begin
              dac_request_write <= 1'b0;
              adc_request_write <= 1'b0;
              adc_request_read  <= 1'b0;
              state             <= DONE_WAIT;
            end
          end
          DONE_WAIT: begin
            if (!spi_busy) begin
              if (opcode == OP_ADC_RD) begin
                rb_word <= {OP_ADC_RD, addr, adc_data_readback};
                state   <= READBACK;
              end else begin
                state <= IDLE;
              end
            end
          end
          READBACK: begin
            if (readback_ready) begin
              readback_write <= 1'b1;
              readback_data  <= rb_word;
              state          <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: vector table, randomized stream against a
// transaction-level model, and hand sequences for stall, timeout and reset.
module tb_control_unit;
  localparam int SPI_TIMEOUT = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_ready, instr_ack;
  logic [31:0] instr_in;
  logic        readback_ready, readback_write;
  logic [31:0] readback_data;
  logic        dac_request_write;
  logic [7:0]  dac_address;
  logic [15:0] dac_data;
  logic        adc_request_write, adc_request_read;
  logic [7:0]  adc_address;
  logic [15:0] adc_data, adc_data_readback;
  logic        spi_busy;

  control_unit #(.SPI_TIMEOUT(SPI_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .instr_ready(instr_ready), .instr_ack(instr_ack), .instr_in(instr_in),
    .readback_ready(readback_ready), .readback_write(readback_write),
    .readback_data(readback_data),
    .dac_request_write(dac_request_write), .dac_address(dac_address), .dac_data(dac_data),
    .adc_request_write(adc_request_write), .adc_request_read(adc_request_read),
    .adc_address(adc_address), .adc_data(adc_data),
    .adc_data_readback(adc_data_readback), .spi_busy(spi_busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // FIFO model, observation logs, SPI responder state
  logic [31:0] fifo_q[$];
  logic [31:0] obs_req[$];
  logic [31:0] obs_rb[$];
  logic [15:0] rd_log[$];
  int          ack_cycles[$];
  int          rb_cycles[$];
  int          ack_count, onehot_err, cyc, req_rise_cyc;
  logic [2:0]  prev_req;
  int          r_phase, r_cnt, fixed_delay, fixed_len;
  bit          r_is_read, stuck, rand_mode, rand_ready, gap_en;
  logic [15:0] fixed_rd;

  task automatic clear_obs();
    obs_req.delete(); obs_rb.delete(); rd_log.delete();
    ack_cycles.delete(); rb_cycles.delete();
    ack_count = 0; onehot_err = 0;
  endtask

  task automatic step();
    logic [2:0] req_now;
    @(negedge clk);
    cyc++;
    req_now = {adc_request_read, adc_request_write, dac_request_write};
    if ($countones(req_now) > 1) onehot_err++;
    if (req_now[0] && !prev_req[0]) begin obs_req.push_back({8'd0, dac_address, dac_data}); req_rise_cyc = cyc; end
    if (req_now[1] && !prev_req[1]) begin obs_req.push_back({8'd1, adc_address, adc_data}); req_rise_cyc = cyc; end
    if (req_now[2] && !prev_req[2]) begin obs_req.push_back({8'd2, adc_address, adc_data}); req_rise_cyc = cyc; end
    prev_req = req_now;
    if (readback_write) begin obs_rb.push_back(readback_data); rb_cycles.push_back(cyc); end
    if (instr_ack) begin
      ack_count++;
      ack_cycles.push_back(cyc);
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    // SPI responder: phase 1 delay, 2 busy, 3 wait request low, 4 unrelated busy burst
    if (r_phase == 0 && req_now != 0 && !stuck) begin
      r_cnt = rand_mode ? int'($urandom_range(0, 4)) : fixed_delay;
      r_is_read = req_now[2];
      r_phase = 1;
    end else if (r_phase == 0 && req_now == 0 && rand_mode && $urandom_range(0, 15) == 0) begin
      spi_busy = 1'b1; r_cnt = int'($urandom_range(1, 4)); r_phase = 4;
    end else if (r_phase == 4) begin
      r_cnt--;
      if (r_cnt == 0) begin spi_busy = 1'b0; r_phase = 0; end
    end else if (r_phase == 2) begin
      r_cnt--;
      if (r_cnt == 0) begin
        spi_busy = 1'b0;
        adc_data_readback = rand_mode ? 16'($urandom) : fixed_rd;
        if (r_is_read) rd_log.push_back(adc_data_readback);
        r_phase = 3;
      end
    end else if (r_phase == 3) begin
      if (req_now == 0) r_phase = 0;
    end
    if (r_phase == 1) begin
      if (r_cnt == 0) begin
        spi_busy = 1'b1;
        r_cnt = rand_mode ? int'($urandom_range(1, 4)) : fixed_len;
        r_phase = 2;
      end else r_cnt--;
    end
    if (rand_ready) readback_ready = ($urandom_range(0, 3) != 0);
    instr_ready = (fifo_q.size() != 0) && !(gap_en && $urandom_range(0, 3) == 0);
    instr_in = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  endtask

  task automatic drain(input string name, input int budget, input int settle);
    int n = 0;
    while (fifo_q.size() != 0 && n < budget) begin step(); n++; end
    check({name, "_fifo_drained"}, fifo_q.size(), 0);
    repeat (settle) step();
  endtask

  task automatic quiet_responder();
    r_phase = 0; spi_busy = 1'b0; stuck = 1'b0;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [15:0] rd;
    int          n_req;
    logic [31:0] exp_req;
    int          n_rb;
    logic [31:0] exp_rb;
  } vec_t;

  vec_t vecs[7];

  logic [31:0] rnd_instr[$];
  logic [31:0] exp_req[$];
  logic [31:0] exp_rb[$];

  initial begin
    vecs[0] = '{32'h0C180060, 16'h0000, 1, 32'h00180060, 0, 32'h0};
    vecs[1] = '{32'h14180060, 16'h0000, 1, 32'h01180060, 0, 32'h0};
    vecs[2] = '{32'h18050000, 16'hBEEF, 1, 32'h02050000, 1, 32'h1805BEEF};
    vecs[3] = '{32'h00000000, 16'h0000, 0, 32'h0,        0, 32'h0};
    vecs[4] = '{32'h7F123456, 16'h0000, 0, 32'h0,        1, 32'hFF7F0000};
    vecs[5] = '{32'h0CFFABCD, 16'h0000, 1, 32'h00FFABCD, 0, 32'h0};
    vecs[6] = '{32'h18A51234, 16'h0001, 1, 32'h02A51234, 1, 32'h18A50001};

    reset = 1'b1; instr_ready = 1'b0; instr_in = '0; readback_ready = 1'b1;
    adc_data_readback = '0; spi_busy = 1'b0; prev_req = '0; cyc = 0; req_rise_cyc = 0;
    r_phase = 0; r_cnt = 0; stuck = 0; rand_mode = 0; rand_ready = 0; gap_en = 0;
    fixed_delay = 3; fixed_len = 2; fixed_rd = '0;
    clear_obs();
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {instr_ack, readback_write, readback_data, dac_request_write, dac_address, dac_data,
           adc_request_write, adc_request_read, adc_address, adc_data}, '0);
    reset = 1'b0;

    // Single-instruction vector table
    for (int i = 0; i < 7; i++) begin
      clear_obs();
      fixed_delay = 3; fixed_len = 2; fixed_rd = vecs[i].rd;
      fifo_q.push_back(vecs[i].instr);
      drain($sformatf("vec%0d", i), 20, 30);
      check($sformatf("vec%0d_acks", i), ack_count, 1);
      check($sformatf("vec%0d_req_count", i), obs_req.size(), vecs[i].n_req);
      if (vecs[i].n_req > 0 && obs_req.size() > 0)
        check($sformatf("vec%0d_req", i), obs_req[0], vecs[i].exp_req);
      check($sformatf("vec%0d_rb_count", i), obs_rb.size(), vecs[i].n_rb);
      if (vecs[i].n_rb > 0 && obs_rb.size() > 0)
        check($sformatf("vec%0d_rb", i), obs_rb[0], vecs[i].exp_rb);
      check($sformatf("vec%0d_onehot", i), onehot_err, 0);
    end

    // Readback stall: write is delayed, not lost, and data holds afterwards
    clear_obs();
    readback_ready = 1'b0; fixed_rd = 16'hBEEF;
    fifo_q.push_back(32'h18050000);
    drain("stall", 20, 30);
    check("stall_no_write", obs_rb.size(), 0);
    readback_ready = 1'b1;
    repeat (5) step();
    check("stall_write_count", obs_rb.size(), 1);
    if (obs_rb.size() > 0) check("stall_write_data", obs_rb[0], 32'h1805BEEF);
    check("readback_data_hold", readback_data, 32'h1805BEEF);

    // Continuous stream: one ack per word, order preserved
    clear_obs();
    fixed_delay = 1; fixed_len = 1;
    for (int k = 0; k < 2; k++) begin
      fifo_q.push_back(32'h0C180060); fifo_q.push_back(32'h14180060);
      fifo_q.push_back(32'h00000000); fifo_q.push_back(32'h00000000);
    end
    drain("stream", 200, 30);
    check("stream_acks", ack_count, 8);
    check("stream_req_count", obs_req.size(), 4);
    for (int k = 0; k < 4 && k < obs_req.size(); k++)
      check($sformatf("stream_req%0d", k), obs_req[k], (k % 2 == 0) ? 32'h00180060 : 32'h01180060);
    check("stream_no_rb", obs_rb.size(), 0);

    // Back-to-back NOPs issue every 2 cycles
    clear_obs();
    repeat (5) fifo_q.push_back(32'h00000000);
    drain("nop", 50, 5);
    check("nop_acks", ack_count, 5);
    if (ack_cycles.size() == 5) check("nop_spacing", ack_cycles[4] - ack_cycles[0], 8);

    // Randomized stream against a transaction-level model
    clear_obs();
    rand_mode = 1; rand_ready = 1; gap_en = 1;
    rnd_instr.delete();
    for (int k = 0; k < 60; k++) begin
      int r;
      logic [7:0] op;
      r = int'($urandom_range(0, 9));
      if (r < 2) op = 8'h00;
      else if (r < 4) op = 8'h0C;
      else if (r < 6) op = 8'h14;
      else if (r < 9) op = 8'h18;
      else op = 8'($urandom_range(8'h20, 8'hFE));
      rnd_instr.push_back({op, 24'($urandom)});
      fifo_q.push_back(rnd_instr[k]);
    end
    drain("rnd", 3000, 60);
    rand_mode = 0; rand_ready = 0; gap_en = 0; readback_ready = 1'b1;
    quiet_responder();
    exp_req.delete(); exp_rb.delete();
    begin
      int ri = 0;
      foreach (rnd_instr[k]) begin
        logic [7:0] op, a;
        logic [15:0] d;
        op = rnd_instr[k][31:24]; a = rnd_instr[k][23:16]; d = rnd_instr[k][15:0];
        if (op == 8'h0C) exp_req.push_back({8'd0, a, d});
        else if (op == 8'h14) exp_req.push_back({8'd1, a, d});
        else if (op == 8'h18) begin
          exp_req.push_back({8'd2, a, d});
          exp_rb.push_back({8'h18, a, (ri < rd_log.size()) ? rd_log[ri] : 16'h0000});
          ri++;
        end else if (op != 8'h00) exp_rb.push_back({8'hFF, op, 16'h0000});
      end
    end
    check("rnd_acks", ack_count, 60);
    check("rnd_onehot", onehot_err, 0);
    check("rnd_req_count", obs_req.size(), exp_req.size());
    for (int k = 0; k < obs_req.size() && k < exp_req.size(); k++)
      check($sformatf("rnd_req%0d", k), obs_req[k], exp_req[k]);
    check("rnd_rb_count", obs_rb.size(), exp_rb.size());
    for (int k = 0; k < obs_rb.size() && k < exp_rb.size(); k++)
      check($sformatf("rnd_rb%0d", k), obs_rb[k], exp_rb[k]);

    // Illegal opcode, then SPI never goes busy: timeout abort
    clear_obs();
    stuck = 1;
    fifo_q.push_back(32'h7F000000); fifo_q.push_back(32'h0C180060);
    begin
      int n = 0;
      while (obs_rb.size() < 2 && n < SPI_TIMEOUT + 200) begin step(); n++; end
    end
    check("timeout_rb_count", obs_rb.size(), 2);
    if (obs_rb.size() == 2) begin
      check("illegal_op_rb", obs_rb[0], 32'hFF7F0000);
      check("timeout_rb", obs_rb[1], 32'hEE0C1800);
      check("timeout_latency", rb_cycles[1] - req_rise_cyc, SPI_TIMEOUT);
      check("timeout_req_dropped", dac_request_write, 1'b0);
    end
    quiet_responder();
    clear_obs();
    fixed_delay = 1; fixed_len = 1;
    fifo_q.push_back(32'h00000000); fifo_q.push_back(32'h14180060);
    drain("post_timeout", 50, 20);
    check("post_timeout_acks", ack_count, 2);
    check("post_timeout_req_count", obs_req.size(), 1);
    if (obs_req.size() > 0) check("post_timeout_req", obs_req[0], 32'h01180060);

    // Reset during ACCEPT_WAIT
    clear_obs();
    fixed_delay = 20; fixed_len = 2;
    fifo_q.push_back(32'h0C180060);
    begin
      int n = 0;
      while (!dac_request_write && n < 30) begin step(); n++; end
    end
    check("rst_req_seen", dac_request_write, 1'b1);
    repeat (2) step();
    reset = 1'b1;
    #1;
    check("rst_mid_outputs",
          {instr_ack, readback_write, readback_data, dac_request_write, dac_address, dac_data,
           adc_request_write, adc_request_read, adc_address, adc_data}, '0);
    quiet_responder();
    repeat (2) step();
    reset = 1'b0;
    clear_obs();
    fixed_delay = 1; fixed_len = 1;
    fifo_q.push_back(32'h14180060);
    drain("post_reset", 20, 20);
    check("post_reset_acks", ack_count, 1);
    check("post_reset_req_count", obs_req.size(), 1);
    if (obs_req.size() > 0) check("post_reset_req", obs_req[0], 32'h01180060);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
